stream_demux: RTL

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake and packet-aware routing. It is the next generation of the team's gate-level 1:4 demux, generalised in data width and channel count. The destination is latched on the first beat of each packet and held until the `last` beat, so a packet never splits across outputs. One output register stage gives one-cycle latency at full throughput. It sits between a single upstream stream source and N downstream consumers.

---
 rtl/stream_demux.sv | 125 ++++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N stream demultiplexer with packet-locked
// routing. The destination is captured on the first beat of a packet and
// held until its last beat. A single holding register gives one cycle of
// latency at full throughput.
//
// Optional feature macro: STREAM_DEMUX_DROPCNT_EN adds an 8-bit saturating
// count of packets discarded because their select was out of range.
//
// state | meaning
// IDLE  | between packets; next accepted beat is a first beat
// ROUTE | inside a packet, beats go to the latched destination
// DROP  | inside a packet with an out-of-range select, beats discarded
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_last,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_last,
`ifdef STREAM_DEMUX_DROPCNT_EN
  output logic [7:0]           drop_cnt,
`endif
  output logic                 busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUTE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  // Channel count widened by one bit so N itself is representable for compare.
  localparam logic [SELW:0] NUM_CH = (SELW + 1)'(N);

  logic [1:0]       state;
  logic [SELW-1:0]  dest;
  logic             hv;
  logic             hl;
  logic [WIDTH-1:0] hd;
  logic [SELW-1:0]  hdest;

  logic             sel_oor;
  logic             drop_beat;
  logic             accept;
  logic             load;
  logic [SELW-1:0]  route_dest;

  assign sel_oor    = ({1'b0, in_sel} >= NUM_CH);
  // A beat that will be discarded never touches the holding register, so it
  // can be taken even while the register is stalled.
  assign drop_beat  = (state == DROP) || ((state == IDLE) && sel_oor);
  assign in_ready   = drop_beat || !hv || out_ready[hdest];
  assign accept     = in_valid && in_ready;
  assign load       = accept && !drop_beat;
  // First beat routes on the live select; later beats use the latched one.
  assign route_dest = (state == IDLE) ? in_sel : dest;

  // Packet state and destination lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dest  <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          dest <= in_sel;
          if (!in_last) state <= sel_oor ? DROP : ROUTE;
        end
        ROUTE, DROP: begin
          if (in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: load replaces a drained beat in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv    <= 1'b0;
      hd    <= '0;
      hl    <= 1'b0;
      hdest <= '0;
    end else if (load) begin
      hv    <= 1'b1;
      hd    <= in_data;
      hl    <= in_last;
      hdest <= route_dest;
    end else if (hv && out_ready[hdest]) begin
      hv    <= 1'b0;
    end
  end

  // Per-channel valid and last decoded from the held destination.
  always_comb begin
    out_valid = '0;
    out_last  = '0;
    for (int k = 0; k < N; k++) begin
      out_valid[k] = hv && (hdest == SELW'(k));
      out_last[k]  = hv && hl && (hdest == SELW'(k));
    end
  end

  assign out_data = {N{hd}};
  assign busy     = (state != IDLE);

`ifdef STREAM_DEMUX_DROPCNT_EN
  // Count discarded packets on their first beat, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && (state == IDLE) && sel_oor && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
